// File: rtl/rst_synchronizer_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_synchronizer_if
// Brief    : Reset request / synchronized reset bundle for one clock domain.
// Revision : 1.0 - initial release
// ============================================================================
interface rst_synchronizer_if;
    logic rstN;
    logic sync_rstN;
    logic sync_rst;
    logic release_pulse;

    modport master (
        input  rstN,
        output sync_rstN,
        output sync_rst,
        output release_pulse
    );

    modport slave (
        output rstN,
        input  sync_rstN,
        input  sync_rst,
        input  release_pulse
    );
endinterface
`default_nettype wire

// File: rtl/rst_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : rst_synchronizer
// Brief    : Asynchronous-assert / synchronous-release reset bridge with an
//            optional post-release hold and a one-cycle release pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rst_synchronizer #(
    parameter int SYNC_STAGES = 2,   // 2..8
    parameter int HOLD_CYCLES = 0    // 0..255
) (
    input wire clk,
    input wire rst,
    rst_synchronizer_if.master rstBus
);

    localparam int c_CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES);

    logic                   w_rstN;
    logic [SYNC_STAGES-1:0] r_chain;
    logic [SYNC_STAGES-1:0] w_chainNext;
    logic [c_CNT_W-1:0]     r_holdCnt;
    logic [c_CNT_W-1:0]     w_cntNext;
    logic                   w_releaseNext;
    logic                   r_syncRstN;
    logic                   r_releasePulse;

    assign w_rstN = rstBus.rstN;

    // Stage 0 samples a constant 1; that flop is the only one that can go
    // metastable when rstN rises close to an edge.
    assign w_chainNext = {r_chain[SYNC_STAGES-2:0], 1'b1};

    // The hold counter only runs once the chain has fully released.
    always_comb begin
        w_cntNext = r_holdCnt;
        if (r_chain[SYNC_STAGES-1] && (r_holdCnt != '0)) begin
            w_cntNext = r_holdCnt - c_CNT_W'(1);
        end
    end

    // Looking at next-state values lets the output flop release on the same
    // edge the chain/counter complete, so no extra cycle is added.
    assign w_releaseNext = w_chainNext[SYNC_STAGES-1] && (w_cntNext == '0);

    always_ff @(posedge clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_chain        <= '0;
            r_holdCnt      <= c_HOLD_LOAD;
            r_syncRstN     <= 1'b0;
            r_releasePulse <= 1'b0;
        end else if (rst) begin
            r_chain        <= '0;
            r_holdCnt      <= c_HOLD_LOAD;
            r_syncRstN     <= 1'b0;
            r_releasePulse <= 1'b0;
        end else begin
            r_chain        <= w_chainNext;
            r_holdCnt      <= w_cntNext;
            r_syncRstN     <= w_releaseNext;
            r_releasePulse <= w_releaseNext && !r_syncRstN;
        end
    end

    assign rstBus.sync_rstN     = r_syncRstN;
    assign rstBus.sync_rst      = ~r_syncRstN;
    assign rstBus.release_pulse = r_releasePulse;

endmodule
`default_nettype wire

// File: tb/tb_rst_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_synchronizer
// Brief    : Directed self-checking bench; one default instance and one with
//            SYNC_STAGES=3, HOLD_CYCLES=4 sharing clk and rst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_synchronizer;

    logic clk;
    logic rst;
    int   numChecks;
    int   numFails;
    int   pulseCnt1;

    rst_synchronizer_if rstIf0 ();
    rst_synchronizer_if rstIf1 ();

    rst_synchronizer u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .rstBus (rstIf0.master)
    );

    rst_synchronizer #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (4)
    ) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .rstBus (rstIf1.master)
    );

    // Rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rstIf1.release_pulse === 1'b1) pulseCnt1 = pulseCnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks = numChecks + 1;
        if (got !== exp) begin
            numFails = numFails + 1;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic waitUntil(input int t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        pulseCnt1 = 0;
        rst       = 1'b0;
        // Start high and drop so the asynchronous clear sees a real edge.
        rstIf0.rstN = 1'b1;
        rstIf1.rstN = 1'b1;
        #1;
        rstIf0.rstN = 1'b0;
        rstIf1.rstN = 1'b0;

        waitUntil(12);
        check("d0_rst_syncN",   32'(rstIf0.sync_rstN),     32'd0);
        check("d0_rst_sync",    32'(rstIf0.sync_rst),      32'd1);
        check("d0_rst_pulse",   32'(rstIf0.release_pulse), 32'd0);
        check("d1_rst_syncN",   32'(rstIf1.sync_rstN),     32'd0);

        waitUntil(20);
        rstIf0.rstN = 1'b1;
        rstIf1.rstN = 1'b1;

        waitUntil(30);
        check("d0_rel_edge1",   32'(rstIf0.sync_rstN),     32'd0);
        waitUntil(40);
        check("d0_rel_edge2",   32'(rstIf0.sync_rstN),     32'd1);
        check("d0_rel_sync",    32'(rstIf0.sync_rst),      32'd0);
        check("d0_rel_pulse",   32'(rstIf0.release_pulse), 32'd1);
        waitUntil(50);
        check("d0_pulse_end",   32'(rstIf0.release_pulse), 32'd0);
        check("d0_steady",      32'(rstIf0.sync_rstN),     32'd1);

        // Asynchronous assert: no clock edge between 70 and 71.
        waitUntil(70);
        rstIf0.rstN = 1'b0;
        #1;
        check("d0_async_syncN", 32'(rstIf0.sync_rstN),     32'd0);
        check("d0_async_sync",  32'(rstIf0.sync_rst),      32'd1);

        waitUntil(76);
        check("d1_hold_edge6",  32'(rstIf1.sync_rstN),     32'd0);
        waitUntil(86);
        check("d1_hold_rel",    32'(rstIf1.sync_rstN),     32'd1);
        check("d1_hold_pulse",  32'(rstIf1.release_pulse), 32'd1);
        waitUntil(96);
        check("d1_pulse_end",   32'(rstIf1.release_pulse), 32'd0);

        waitUntil(100);
        rstIf0.rstN = 1'b1;
        waitUntil(111);
        check("d0_rerel_e1",    32'(rstIf0.sync_rstN),     32'd0);
        waitUntil(116);
        check("d0_rerel_e2",    32'(rstIf0.sync_rstN),     32'd1);
        check("d0_rerel_pulse", 32'(rstIf0.release_pulse), 32'd1);
        waitUntil(126);
        check("d0_rerel_pend",  32'(rstIf0.release_pulse), 32'd0);
        check("d1_pulse_count", 32'(pulseCnt1),            32'd1);

        // Synchronous block reset held across the edge at 135.
        waitUntil(130);
        rst = 1'b1;
        waitUntil(136);
        check("d0_srst_syncN",  32'(rstIf0.sync_rstN),     32'd0);
        check("d0_srst_sync",   32'(rstIf0.sync_rst),      32'd1);
        check("d1_srst_syncN",  32'(rstIf1.sync_rstN),     32'd0);
        waitUntil(140);
        rst = 1'b0;
        waitUntil(146);
        check("d0_srst_e1",     32'(rstIf0.sync_rstN),     32'd0);
        waitUntil(156);
        check("d0_srst_rel",    32'(rstIf0.sync_rstN),     32'd1);
        check("d0_srst_pulse",  32'(rstIf0.release_pulse), 32'd1);

        // Short rstN glitch between edges 185 and 195 must restart release.
        waitUntil(170);
        rstIf0.rstN = 1'b0;
        waitUntil(180);
        rstIf0.rstN = 1'b1;
        waitUntil(186);
        check("d0_gl_pre",      32'(rstIf0.sync_rstN),     32'd0);
        waitUntil(187);
        rstIf0.rstN = 1'b0;
        waitUntil(190);
        rstIf0.rstN = 1'b1;
        waitUntil(196);
        check("d0_gl_e1",       32'(rstIf0.sync_rstN),     32'd0);
        check("d0_gl_e1_pulse", 32'(rstIf0.release_pulse), 32'd0);
        check("d1_srst_e6",     32'(rstIf1.sync_rstN),     32'd0);
        waitUntil(206);
        check("d0_gl_rel",      32'(rstIf0.sync_rstN),     32'd1);
        check("d0_gl_pulse",    32'(rstIf0.release_pulse), 32'd1);
        check("d1_srst_rel",    32'(rstIf1.sync_rstN),     32'd1);
        check("d1_srst_pulse",  32'(rstIf1.release_pulse), 32'd1);
        waitUntil(216);
        check("d1_pulse_total", 32'(pulseCnt1),            32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
        $finish;
    end

endmodule
`default_nettype wire
